// File: rtl/jtag_tap_core.sv
// IEEE 1149.1-style TAP controller: 16-state TMS FSM, instruction register,
// IDCODE/BYPASS/USER data registers, TDI->TDO shifting and user update strobe.
module jtag_tap_core #(
  parameter int                  IR_WIDTH      = 4,
  parameter int                  USER_DR_WIDTH = 8,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR  = 4'b0001,
  parameter logic [IR_WIDTH-1:0] USER_INSTR    = 4'b1000
) (
  input  logic                     clk,
  input  logic                     TRST,
  input  logic                     TMS,
  input  logic                     TDI,
  output logic                     TDO,
  output logic                     TDO_EN,
  output logic [3:0]               state_obs,
  output logic [IR_WIDTH-1:0]      ir_out,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     user_update
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI     = 4'd1,  SEL_DR  = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR  = 4'd5,  PAU_DR  = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR  = 4'd9,  CAP_IR  = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PAU_IR  = 4'd13, EX2_IR  = 4'd14, UPD_IR = 4'd15
  } state_t;

  state_t                   state_q, state_d;
  logic [IR_WIDTH-1:0]      ir_q, ir_sr_q, ir_shift;
  logic [31:0]              id_sr_q;
  logic [USER_DR_WIDTH-1:0] user_sr_q, user_shift, user_dr_out_q;
  logic                     byp_q, user_update_q;
  logic                     sel_idcode, sel_user;

  assign sel_idcode = (ir_q == IDCODE_INSTR);
  assign sel_user   = (ir_q == USER_INSTR) && !sel_idcode;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = TMS ? TLR    : RTI;
      RTI:     state_d = TMS ? SEL_DR : RTI;
      SEL_DR:  state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:   state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_d = TMS ? SEL_DR : RTI;
      SEL_IR:  state_d = TMS ? TLR    : CAP_IR;
      CAP_IR:  state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:   state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Shift helpers written so a one-bit register still elaborates cleanly.
  always_comb begin
    ir_shift               = ir_sr_q >> 1;
    ir_shift[IR_WIDTH-1]   = TDI;
    user_shift             = user_sr_q >> 1;
    user_shift[USER_DR_WIDTH-1] = TDI;
  end

  // Parallel updates fire on entry to the Update states so the new value and
  // the strobe are visible for exactly the cycle the FSM sits in that state.
  always_ff @(posedge clk or posedge TRST) begin
    if (TRST) begin
      state_q       <= TLR;
      ir_q          <= IDCODE_INSTR;
      ir_sr_q       <= '0;
      id_sr_q       <= '0;
      user_sr_q     <= '0;
      byp_q         <= 1'b0;
      user_dr_out_q <= '0;
      user_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      user_update_q <= 1'b0;
      case (state_q)
        CAP_DR: begin
          if (sel_idcode)    id_sr_q   <= IDCODE_VALUE;
          else if (sel_user) user_sr_q <= user_dr_in;
          else               byp_q     <= 1'b0;
        end
        SH_DR: begin
          if (sel_idcode)    id_sr_q   <= {TDI, id_sr_q[31:1]};
          else if (sel_user) user_sr_q <= user_shift;
          else               byp_q     <= TDI;
        end
        CAP_IR:  ir_sr_q <= IR_WIDTH'(2'b01);
        SH_IR:   ir_sr_q <= ir_shift;
        default: ;
      endcase
      if (state_d == UPD_DR && sel_user) begin
        user_dr_out_q <= user_sr_q;
        user_update_q <= 1'b1;
      end
      if (state_d == UPD_IR)   ir_q <= ir_sr_q;
      else if (state_d == TLR) ir_q <= IDCODE_INSTR;
    end
  end

  always_comb begin
    TDO = 1'b0;
    case (state_q)
      SH_IR:   TDO = ir_sr_q[0];
      SH_DR:   TDO = sel_idcode ? id_sr_q[0] : (sel_user ? user_sr_q[0] : byp_q);
      default: TDO = 1'b0;
    endcase
  end

  assign TDO_EN      = (state_q == SH_DR) || (state_q == SH_IR);
  assign state_obs   = state_q;
  assign ir_out      = ir_q;
  assign user_dr_out = user_dr_out_q;
  assign user_update = user_update_q;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Bench for jtag_tap_core: directed scans from the test plan plus random TMS/TDI
// traffic, all compared every cycle against a table-driven TAP model.
module tb_jtag_tap_core;

  localparam logic [3:0]  IDCODE_INSTR = 4'b0001;
  localparam logic [3:0]  USER_INSTR   = 4'b1000;
  localparam logic [31:0] IDCODE_VALUE = 32'h1000_0001;

  logic       clk = 1'b0;
  logic       TRST, TMS, TDI;
  logic       TDO, TDO_EN;
  logic [3:0] state_obs, ir_out;
  logic [7:0] user_dr_in, user_dr_out;
  logic       user_update;

  int checks = 0;
  int failures = 0;

  jtag_tap_core #(
    .IR_WIDTH(4), .USER_DR_WIDTH(8), .IDCODE_VALUE(IDCODE_VALUE),
    .IDCODE_INSTR(IDCODE_INSTR), .USER_INSTR(USER_INSTR)
  ) dut (
    .clk(clk), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .state_obs(state_obs), .ir_out(ir_out), .user_dr_in(user_dr_in),
    .user_dr_out(user_dr_out), .user_update(user_update)
  );

  always #5 clk = ~clk;

  // Transition table straight from the state diagram, indexed by state code.
  int nextOnOne  [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int nextOnZero [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};

  // TMS paths from Test_Logic_Reset to every state, LSB applied first.
  logic [7:0] pathBits [16] = '{8'b0, 8'b0, 8'b10, 8'b010, 8'b0010, 8'b1010,
                                8'b01010, 8'b101010, 8'b11010, 8'b110, 8'b0110,
                                8'b00110, 8'b10110, 8'b010110, 8'b1010110, 8'b110110};
  int pathLen [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

  int         mState;
  logic [3:0] mIr, mIrSh;
  logic [31:0] mId;
  logic [7:0] mUser, mUdo;
  logic       mByp, mUpd;

  function automatic int selectedDr();
    if (mIr == IDCODE_INSTR) return 0;
    if (mIr == USER_INSTR)   return 1;
    return 2;
  endfunction

  task automatic modelReset();
    mState = 0; mIr = IDCODE_INSTR; mIrSh = 0; mId = 0;
    mUser = 0; mUdo = 0; mByp = 0; mUpd = 0;
  endtask

  task automatic modelStep(input bit tms, input bit tdi);
    int ns;
    int sel;
    ns  = tms ? nextOnOne[mState] : nextOnZero[mState];
    sel = selectedDr();
    mUpd = 1'b0;
    if (mState == 3) begin
      if (sel == 0)      mId = IDCODE_VALUE;
      else if (sel == 1) mUser = user_dr_in;
      else               mByp = 1'b0;
    end else if (mState == 4) begin
      if (sel == 0)      mId = (mId >> 1) + (32'(tdi) << 31);
      else if (sel == 1) mUser = (mUser >> 1) + (8'(tdi) << 7);
      else               mByp = tdi;
    end else if (mState == 10) begin
      mIrSh = 4'd1;
    end else if (mState == 11) begin
      mIrSh = (mIrSh >> 1) + (4'(tdi) << 3);
    end
    if (ns == 8 && sel == 1) begin
      mUdo = mUser;
      mUpd = 1'b1;
    end
    if (ns == 15)     mIr = mIrSh;
    else if (ns == 0) mIr = IDCODE_INSTR;
    mState = ns;
  endtask

  function automatic logic modelTdo();
    int sel;
    sel = selectedDr();
    if (mState == 11) return mIrSh[0];
    if (mState == 4)  return (sel == 0) ? mId[0] : ((sel == 1) ? mUser[0] : mByp);
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("state_obs", 32'(state_obs), 32'(mState));
    checkOutput("ir_out", 32'(ir_out), 32'(mIr));
    checkOutput("tdo", 32'(TDO), 32'(modelTdo()));
    checkOutput("tdo_en", 32'(TDO_EN), 32'((mState == 4) || (mState == 11)));
    checkOutput("user_dr_out", 32'(user_dr_out), 32'(mUdo));
    checkOutput("user_update", 32'(user_update), 32'(mUpd));
  endtask

  // Drive one TCK cycle; outputs are compared on the following falling edge.
  task automatic applyStimulus(input bit tms, input bit tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge clk);
    modelStep(tms, tdi);
    @(negedge clk);
    checkAll();
  endtask

  task automatic doReset();
    TRST = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    @(negedge clk);
    checkAll();
    TRST = 1'b0;
  endtask

  task automatic loadIr(input logic [3:0] v, output logic [3:0] irTdo);
    irTdo = '0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      irTdo[i] = TDO;
      applyStimulus(i == 3, v[i]);
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic scanDr(input int n, input logic [31:0] din, output logic [31:0] dout,
                        output logic [31:0] enBits, output logic [7:0] udoAtUpd,
                        output logic updAtUpd, output logic updAfter);
    dout = '0;
    enBits = '0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i]   = TDO;
      enBits[i] = TDO_EN;
      applyStimulus(i == n - 1, din[i]);
    end
    applyStimulus(1'b1, 1'b0);
    udoAtUpd = user_dr_out;
    updAtUpd = user_update;
    applyStimulus(1'b0, 1'b0);
    updAfter = user_update;
  endtask

  initial begin
    logic [31:0] dout, enBits;
    logic [7:0]  udo, pauseOut;
    logic [3:0]  irTdo;
    logic        updAt, updAfter;

    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; user_dr_in = 8'h00;
    modelReset();
    #2;
    checkAll();
    @(negedge clk);
    TRST = 1'b0;

    applyStimulus(1'b0, 1'b0);
    checkOutput("rti_after_reset", 32'(state_obs), 32'd1);
    checkOutput("ir_after_reset", 32'(ir_out), 32'(IDCODE_INSTR));

    scanDr(32, 32'h0, dout, enBits, udo, updAt, updAfter);
    checkOutput("idcode_stream", dout, 32'h1000_0001);
    checkOutput("idcode_tdo_en", enBits, 32'hFFFF_FFFF);
    checkOutput("idcode_no_update", 32'(updAt), 32'd0);

    loadIr(4'b1111, irTdo);
    checkOutput("ir_capture_stream", 32'(irTdo), 32'b0001);
    checkOutput("ir_bypass_loaded", 32'(ir_out), 32'hF);
    scanDr(4, 32'b1101, dout, enBits, udo, updAt, updAfter);
    checkOutput("bypass_stream", 32'(dout[3:0]), 32'b1010);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("tlr_reloads_ir", 32'(ir_out), 32'(IDCODE_INSTR));

    loadIr(USER_INSTR, irTdo);
    checkOutput("ir_user_loaded", 32'(ir_out), 32'(USER_INSTR));
    user_dr_in = 8'hA5;
    scanDr(8, 32'h3C, dout, enBits, udo, updAt, updAfter);
    checkOutput("user_capture_stream", 32'(dout[7:0]), 32'hA5);
    checkOutput("user_update_value", 32'(udo), 32'h3C);
    checkOutput("user_update_pulse", 32'(updAt), 32'd1);
    checkOutput("user_update_single", 32'(updAfter), 32'd0);

    // Split user scan with a three-cycle pause in the middle.
    user_dr_in = 8'h5A;
    pauseOut = '0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pauseOut[i] = TDO;
      applyStimulus(i == 3, 8'hC3 >> i);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("pause_state", 32'(state_obs), 32'd6);
      checkOutput("pause_holds_udo", 32'(user_dr_out), 32'h3C);
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 4; i < 8; i++) begin
      pauseOut[i] = TDO;
      applyStimulus(i == 7, 8'hC3 >> i);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("pause_scan_update", 32'(user_dr_out), 32'hC3);
    checkOutput("pause_scan_pulse", 32'(user_update), 32'd1);
    checkOutput("pause_scan_stream", 32'(pauseOut), 32'h5A);
    applyStimulus(1'b0, 1'b0);

    user_dr_in = 8'h96;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("zero_shift_update", 32'(user_dr_out), 32'h96);
    applyStimulus(1'b0, 1'b0);

    user_dr_in = 8'h77;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    #2;
    TRST = 1'b1;
    #1;
    checkOutput("abort_state", 32'(state_obs), 32'd0);
    checkOutput("abort_ir", 32'(ir_out), 32'(IDCODE_INSTR));
    checkOutput("abort_udo", 32'(user_dr_out), 32'd0);
    checkOutput("abort_update", 32'(user_update), 32'd0);
    checkOutput("abort_tdo_en", 32'(TDO_EN), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("abort_no_pulse", 32'(user_update), 32'd0);
    @(negedge clk);
    checkAll();
    TRST = 1'b0;

    for (int s = 0; s < 16; s++) begin
      doReset();
      for (int k = 0; k < pathLen[s]; k++) applyStimulus(pathBits[s][k], 1'b0);
      checkOutput("reach_state", 32'(state_obs), 32'(s));
      for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0);
      checkOutput("five_tms_to_tlr", 32'(state_obs), 32'd0);
    end

    applyStimulus(1'b0, 1'b0);
    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 249) == 0) doReset();
      if (it % 16 == 0) user_dr_in = 8'($urandom);
      if (it % 150 == 75) begin
        loadIr(($urandom_range(0, 1) == 1) ? USER_INSTR : 4'($urandom), irTdo);
      end
      applyStimulus($urandom_range(0, 99) < 35, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
